// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipe: per-cycle load/squash enables for PC and
// pipe registers, plus saturating stall and flush counters for performance debug.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_icache_resp,
    input  logic             i_dmem_req,
    input  logic             i_dcache_resp,
    input  logic             i_idex_load,
    input  logic [2:0]       i_idex_dest,
    input  logic [2:0]       i_ifid_src1,
    input  logic [2:0]       i_ifid_src2,
    input  logic             i_ifid_use_src1,
    input  logic             i_ifid_use_src2,
    input  logic             i_redirect,
    output logic             o_load_pc,
    output logic             o_load_ifid,
    output logic             o_load_idex,
    output logic             o_load_exme,
    output logic             o_load_mewb,
    output logic             o_squash_ifid,
    output logic             o_squash_idex,
    output logic             o_squash_exme,
    output logic             o_pc_sel_redirect,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count
);

    // state      | meaning
    // RUN        | normal operation, hazards resolved in priority order
    // FLUSH_WAIT | wrong-path fetch still in flight; discard its response
    typedef enum logic {
        RUN        = 1'b0,
        FLUSH_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    logic w_mem_stall;
    logic w_luh;
    logic w_redirect_accept;
    logic w_enter_flush_wait;

    assign w_mem_stall = i_dmem_req & ~i_dcache_resp;
    assign w_luh = i_idex_load &
                   ((i_ifid_use_src1 & (i_ifid_src1 == i_idex_dest)) |
                    (i_ifid_use_src2 & (i_ifid_src2 == i_idex_dest)));

    // A redirect held during a dcache miss is only accepted once the access completes.
    assign w_redirect_accept  = (r_state == RUN) & ~w_mem_stall & i_redirect;
    assign w_enter_flush_wait = w_redirect_accept & ~i_icache_resp;

    always_comb begin
        o_load_pc         = 1'b1;
        o_load_ifid       = 1'b1;
        o_load_idex       = 1'b1;
        o_load_exme       = 1'b1;
        o_load_mewb       = 1'b1;
        o_squash_ifid     = 1'b0;
        o_squash_idex     = 1'b0;
        o_squash_exme     = 1'b0;
        o_pc_sel_redirect = 1'b0;
        if (i_reset) begin
            o_load_pc     = 1'b0;
            o_load_ifid   = 1'b0;
            o_load_idex   = 1'b0;
            o_load_exme   = 1'b0;
            o_load_mewb   = 1'b0;
            o_squash_ifid = 1'b1;
            o_squash_idex = 1'b1;
            o_squash_exme = 1'b1;
        end else if (r_state == FLUSH_WAIT) begin
            o_load_pc     = 1'b0;
            o_squash_ifid = 1'b1;
        end else if (w_mem_stall) begin
            o_load_pc   = 1'b0;
            o_load_ifid = 1'b0;
            o_load_idex = 1'b0;
            o_load_exme = 1'b0;
            o_load_mewb = 1'b0;
        end else if (i_redirect) begin
            o_squash_ifid     = 1'b1;
            o_squash_idex     = 1'b1;
            o_squash_exme     = 1'b1;
            o_pc_sel_redirect = 1'b1;
        end else if (w_luh) begin
            o_load_pc     = 1'b0;
            o_load_ifid   = 1'b0;
            o_squash_idex = 1'b1;
        end else if (~i_icache_resp) begin
            o_load_pc     = 1'b0;
            o_squash_ifid = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= RUN;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            case (r_state)
                RUN:        if (w_enter_flush_wait) r_state <= FLUSH_WAIT;
                FLUSH_WAIT: if (i_icache_resp)      r_state <= RUN;
                default:                            r_state <= RUN;
            endcase
            if (~o_load_pc && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + 1'b1;
            if (w_redirect_accept && (r_flush_count != {CNT_W{1'b1}}))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end

    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a reference model pushes expected enables per
// driven cycle; they are popped and compared on the falling edge, counters after the edge.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic clk = 1'b0;
    logic reset, icache_resp, dmem_req, dcache_resp, idex_load;
    logic [2:0] idex_dest, ifid_src1, ifid_src2;
    logic use1, use2, redirect;
    logic load_pc, load_ifid, load_idex, load_exme, load_mewb;
    logic squash_ifid, squash_idex, squash_exme, pc_sel;
    logic [CNT_W-1:0] stall_count, flush_count;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_reset(reset), .i_icache_resp(icache_resp),
        .i_dmem_req(dmem_req), .i_dcache_resp(dcache_resp),
        .i_idex_load(idex_load), .i_idex_dest(idex_dest),
        .i_ifid_src1(ifid_src1), .i_ifid_src2(ifid_src2),
        .i_ifid_use_src1(use1), .i_ifid_use_src2(use2),
        .i_redirect(redirect),
        .o_load_pc(load_pc), .o_load_ifid(load_ifid), .o_load_idex(load_idex),
        .o_load_exme(load_exme), .o_load_mewb(load_mewb),
        .o_squash_ifid(squash_ifid), .o_squash_idex(squash_idex),
        .o_squash_exme(squash_exme), .o_pc_sel_redirect(pc_sel),
        .o_stall_count(stall_count), .o_flush_count(flush_count)
    );

    // {load_pc, load_ifid, load_idex, load_exme, load_mewb, sq_ifid, sq_idex, sq_exme, pc_sel}
    localparam logic [8:0] ADV   = 9'b11111_000_0;
    localparam logic [8:0] RST   = 9'b00000_111_0;
    localparam logic [8:0] FRZ   = 9'b00000_000_0;
    localparam logic [8:0] REDIR = 9'b11111_111_1;
    localparam logic [8:0] LUH   = 9'b10111_010_0 & 9'b00111_010_0;
    localparam logic [8:0] IMISS = 9'b01111_100_0;

    logic [8:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    bit m_fw;
    logic [CNT_W-1:0] m_stall, m_flush;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model_out();
        logic ms, lh;
        ms = dmem_req & ~dcache_resp;
        lh = idex_load & ((use1 & (ifid_src1 == idex_dest)) | (use2 & (ifid_src2 == idex_dest)));
        if (reset)         return RST;
        if (m_fw)          return IMISS;
        if (ms)            return FRZ;
        if (redirect)      return REDIR;
        if (lh)            return LUH;
        if (!icache_resp)  return IMISS;
        return ADV;
    endfunction

    task automatic idle();
        reset = 0; icache_resp = 1; dmem_req = 0; dcache_resp = 0;
        idex_load = 0; idex_dest = 0; ifid_src1 = 0; ifid_src2 = 0;
        use1 = 0; use2 = 0; redirect = 0;
    endtask

    task automatic step(input string tag, input bit chk_cnt = 1'b1);
        logic [8:0] e;
        logic ms;
        e = model_out();
        exp_q.push_back(e);
        ms = dmem_req & ~dcache_resp;
        @(negedge clk);
        chk(tag, {load_pc, load_ifid, load_idex, load_exme, load_mewb,
                  squash_ifid, squash_idex, squash_exme, pc_sel}, exp_q.pop_front());
        if (reset) begin
            m_fw = 0; m_stall = '0; m_flush = '0;
        end else begin
            if (!e[8] && m_stall != CNT_MAX) m_stall++;
            if (!m_fw && !ms && redirect) begin
                if (m_flush != CNT_MAX) m_flush++;
                if (!icache_resp) m_fw = 1;
            end else if (m_fw && icache_resp) begin
                m_fw = 0;
            end
        end
        @(posedge clk);
        #1;
        if (chk_cnt) begin
            chk({tag, "_stall"}, stall_count, m_stall);
            chk({tag, "_flush"}, flush_count, m_flush);
        end
    endtask

    initial begin
        m_fw = 0; m_stall = '0; m_flush = '0;
        idle();
        reset = 1;
        step("reset");
        chk("reset_stall0", stall_count, 0);
        idle();

        for (int i = 0; i < 10; i++) step("straight");
        chk("t1_stall", stall_count, 0);

        idex_load = 1; idex_dest = 3'd1; ifid_src1 = 3'd1; use1 = 1;
        step("luh_src1");
        idle();
        step("luh_after");
        chk("t2_stall", stall_count, 1);
        idex_load = 1; idex_dest = 3'd5; ifid_src2 = 3'd5; use2 = 1; ifid_src1 = 3'd5; use1 = 0;
        step("luh_src2");
        use2 = 0;
        step("luh_nouse");
        idle();

        dmem_req = 1;
        for (int i = 0; i < 4; i++) step("dmiss");
        dcache_resp = 1;
        step("dhit");
        idle();
        chk("t3_stall", stall_count, 6);

        redirect = 1;
        step("redir_hit");
        idle();
        step("after_redir");
        chk("t4_flush", flush_count, 1);

        redirect = 1; icache_resp = 0;
        step("redir_miss");
        redirect = 0;
        for (int i = 0; i < 3; i++) step("fw_wait");
        icache_resp = 1; redirect = 1; dmem_req = 1;
        step("fw_resp");
        idle();
        step("fw_back_run");
        chk("t5_stall", stall_count, 10);
        chk("t5_flush", flush_count, 2);

        dmem_req = 1; redirect = 1;
        step("stall_vs_redir");
        dcache_resp = 1;
        step("redir_after_stall");
        idle();
        redirect = 1; idex_load = 1; idex_dest = 3'd2; ifid_src1 = 3'd2; use1 = 1;
        step("redir_vs_luh");
        idle();
        chk("sim_flush", flush_count, 4);

        redirect = 1; icache_resp = 0;
        step("redir_miss2");
        redirect = 0;
        reset = 1;
        step("reset_in_fw");
        idle();
        step("run_after_reset");
        chk("rst_fw_flush", flush_count, 0);

        icache_resp = 0;
        for (int i = 0; i < 70000; i++) step("long_miss", (i % 4096) == 0);
        chk("sat_stall", stall_count, 16'hFFFF);
        reset = 1;
        step("reset_sat");
        chk("reset_sat_stall", stall_count, 0);
        idle();
        step("final_adv");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Stall/flush controller driving the load and squash (synchronous reset) inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Decides each cycle which stages advance, hold or become NOPs, based on:
  - icache and dcache responses,
  - load-use hazards between the ID and EX stages,
  - control-flow redirects resolved in MEM (taken BR, JMP, JSR, TRAP).
- Also keeps saturating stall and flush counters for performance debug.

Parameters:
CNT_W, 16, width of the stall_count and flush_count counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
icache_resp  in  1  fetch at current PC complete; held high with stable data while PC is unchanged
dmem_req  in  1  EX/MEM instruction accesses dcache (read or write)
dcache_resp  in  1  dcache access complete this cycle
idex_load  in  1  ID/EX instruction is a load (LDR, LDB, LDI)
idex_dest  in  3  ID/EX destination register
ifid_src1, ifid_src2  in  3 each  IF/ID source registers
ifid_use_src1, ifid_use_src2  in  1 each  IF/ID actually reads src1/src2
redirect  in  1  EX/MEM holds a resolved taken control transfer; held for the whole time the instruction sits in MEM
load_pc, load_ifid, load_idex, load_exme, load_mewb  out  1 each  pipe register load enables
squash_ifid, squash_idex, squash_exme  out  1 each  drive the pipe register reset inputs (NOP insertion; overrides load)
pc_sel_redirect  out  1  PC mux selects the redirect target
stall_count  out  CNT_W  cycles with load_pc=0 outside reset, saturating
flush_count  out  CNT_W  redirects accepted, saturating

Behaviour:
- Reset (takes effect at the clock edge while reset=1):
  - state=RUN, counters=0.
  - While reset=1, outputs are forced: all squash_*=1, all load_*=0, pc_sel_redirect=0.
- Outputs are combinational from state and inputs. State and counters are registered.
- Derived terms:
  - mem_stall = dmem_req & ~dcache_resp
  - luh = idex_load & ((ifid_use_src1 & ifid_src1==idex_dest) | (ifid_use_src2 & ifid_src2==idex_dest))
- Default when no condition below applies (all load_*=1, squash_*=0, pc_sel_redirect=0): full advance.
- RUN state, cases evaluated in priority order:
  1. mem_stall: all load_*=0, no squash. The whole pipe freezes and MEM/WB holds; repeated writeback is idempotent.
  2. redirect:
     - squash_ifid, squash_idex, squash_exme=1; load_pc=1; pc_sel_redirect=1; load_mewb=1.
     - flush_count increments.
     - If icache_resp=0 this cycle, next state is FLUSH_WAIT; otherwise stay in RUN.
  3. luh: load_pc=0, load_ifid=0, squash_idex=1 (bubble into EX); load_exme=1, load_mewb=1.
  4. ~icache_resp: load_pc=0, squash_ifid=1 (IF/ID contents move to ID/EX, IF/ID becomes NOP); load_idex, load_exme, load_mewb=1.
- FLUSH_WAIT state:
  - The fetch still in flight belongs to the wrong path and must be discarded.
  - Every cycle: load_pc=0, squash_ifid=1, other loads=1, pc_sel_redirect=0.
  - When icache_resp=1: discard that response, load_pc stays 0, next state RUN. The next RUN cycle fetches at the redirect target.
  - mem_stall and redirect cannot occur in this state (pipe holds only NOPs plus the branch in WB). Ignore them if asserted.
- stall_count increments on every non-reset cycle with load_pc=0, in either state.
- Both counters saturate at 2^CNT_W-1; no wrap.
- reset asserted mid-stall or in FLUSH_WAIT: return to RUN next cycle and clear counters.
- Simultaneous conditions:
  - mem_stall with redirect: stall wins; redirect is acted on in the first cycle dcache_resp=1.
  - redirect with luh: redirect wins (the hazard instruction is squashed).

Test Plan:
1. Straight-line code, icache_resp=1, no hazards, 10 cycles → all load_*=1, squash_*=0 every cycle; stall_count=0.
2. LDR R1 in ID/EX (idex_load=1, idex_dest=1), ADD reading R1 in IF/ID (ifid_src1=1, use=1) → one cycle of load_pc=0, load_ifid=0, squash_idex=1; next cycle (idex_load=0) full advance; stall_count=1.
3. dmem_req=1, dcache_resp low for 4 cycles then high → 4 cycles all load_*=0, fifth cycle all load_*=1; stall_count=4.
4. redirect=1 with icache_resp=1 → squash_ifid/idex/exme=1, pc_sel_redirect=1, load_pc=1 for one cycle; flush_count=1; state stays RUN.
5. redirect=1 with icache_resp=0, then icache_resp low 3 more cycles then high → enter FLUSH_WAIT; squash_ifid=1 and load_pc=0 for 4 cycles, response discarded; RUN next cycle; stall_count=4.
6. Hold icache_resp=0 for 70000 cycles → stall_count saturates at 0xFFFF; then reset=1 for one cycle → counters 0, state RUN, squash_* high during reset.
